// File: rtl/seq_sample_scheduler.sv
// Sample-rate scheduler: divides the system clock into a sample strobe, captures three
// ADC phases per strobe and issues them one at a time to a shared MAC over a handshake.
module seq_sample_scheduler #(
    parameter int DIV   = 100,
    parameter int NSAMP = 200
) (
    input  logic               clk,
    input  logic               rst,
    input  logic signed [13:0] Va,
    input  logic signed [13:0] Vb,
    input  logic signed [13:0] Vc,
    output logic               dclk,
    output logic [7:0]         k,
    output logic               mac_start,
    output logic [1:0]         mac_sel,
    output logic signed [13:0] mac_x,
    output logic [7:0]         mac_k,
    input  logic               mac_done,
    output logic               frame_done,
    output logic               overrun
);

    localparam int          DATA_W   = 14;
    localparam logic [15:0] DIV_LAST = 16'(DIV - 1);
    localparam logic [15:0] DIV_HALF = 16'(DIV / 2);
    localparam logic [7:0]  K_LAST   = 8'(NSAMP - 1);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE_A,
        WAIT_A,
        ISSUE_B,
        WAIT_B,
        ISSUE_C,
        WAIT_C,
        ADVANCE
    } state_t;

    state_t                    state_q, state_d;
    logic [15:0]               div_cnt_q, div_cnt_d;
    logic [7:0]                k_q, k_d;
    logic signed [DATA_W-1:0]  cap_a_q, cap_a_d;
    logic signed [DATA_W-1:0]  cap_b_q, cap_b_d;
    logic signed [DATA_W-1:0]  cap_c_q, cap_c_d;
    logic [1:0]                mac_sel_q, mac_sel_d;
    logic signed [DATA_W-1:0]  mac_x_q, mac_x_d;
    logic [7:0]                mac_k_q, mac_k_d;
    logic                      overrun_q, overrun_d;
    logic                      stb;

    function automatic logic [7:0] next_index(input logic [7:0] idx);
        return (idx == K_LAST) ? 8'd0 : idx + 8'd1;
    endfunction

    always_comb begin
        div_cnt_d = (div_cnt_q == DIV_LAST) ? 16'd0 : div_cnt_q + 16'd1;
        stb       = (div_cnt_q == DIV_LAST);
    end

    always_comb begin
        state_d    = state_q;
        k_d        = k_q;
        cap_a_d    = cap_a_q;
        cap_b_d    = cap_b_q;
        cap_c_d    = cap_c_q;
        mac_sel_d  = mac_sel_q;
        mac_x_d    = mac_x_q;
        mac_k_d    = mac_k_q;
        mac_start  = 1'b0;
        frame_done = 1'b0;
        // A strobe outside IDLE (including ADVANCE) is a dropped sample.
        overrun_d  = overrun_q | (stb && (state_q != IDLE));

        case (state_q)
            IDLE: begin
                if (stb) begin
                    cap_a_d   = Va;
                    cap_b_d   = Vb;
                    cap_c_d   = Vc;
                    mac_sel_d = 2'd0;
                    mac_x_d   = Va;
                    mac_k_d   = k_q;
                    state_d   = ISSUE_A;
                end
            end
            ISSUE_A: begin
                mac_start = 1'b1;
                state_d   = WAIT_A;
            end
            WAIT_A: begin
                if (mac_done) begin
                    mac_sel_d = 2'd1;
                    mac_x_d   = cap_b_q;
                    mac_k_d   = k_q;
                    state_d   = ISSUE_B;
                end
            end
            ISSUE_B: begin
                mac_start = 1'b1;
                state_d   = WAIT_B;
            end
            WAIT_B: begin
                if (mac_done) begin
                    mac_sel_d = 2'd2;
                    mac_x_d   = cap_c_q;
                    mac_k_d   = k_q;
                    state_d   = ISSUE_C;
                end
            end
            ISSUE_C: begin
                mac_start = 1'b1;
                state_d   = WAIT_C;
            end
            WAIT_C: begin
                if (mac_done) begin
                    state_d = ADVANCE;
                end
            end
            ADVANCE: begin
                frame_done = (k_q == K_LAST);
                k_d        = next_index(k_q);
                state_d    = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            div_cnt_q <= 16'd0;
            k_q       <= 8'd0;
            cap_a_q   <= '0;
            cap_b_q   <= '0;
            cap_c_q   <= '0;
            mac_sel_q <= 2'd0;
            mac_x_q   <= '0;
            mac_k_q   <= 8'd0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            div_cnt_q <= div_cnt_d;
            k_q       <= k_d;
            cap_a_q   <= cap_a_d;
            cap_b_q   <= cap_b_d;
            cap_c_q   <= cap_c_d;
            mac_sel_q <= mac_sel_d;
            mac_x_q   <= mac_x_d;
            mac_k_q   <= mac_k_d;
            overrun_q <= overrun_d;
        end
    end

    assign dclk    = (div_cnt_q < DIV_HALF);
    assign k       = k_q;
    assign mac_sel = mac_sel_q;
    assign mac_x   = mac_x_q;
    assign mac_k   = mac_k_q;
    assign overrun = overrun_q;

endmodule

// File: tb/tb_seq_sample_scheduler.sv
// Directed bench for seq_sample_scheduler at DIV=20, NSAMP=4: per-sample vector table
// plus hand sequences for spurious handshakes, overrun and mid-sequence reset.
module tb_seq_sample_scheduler;

    localparam int DIV   = 20;
    localparam int NSAMP = 4;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic signed [13:0] Va = '0, Vb = '0, Vc = '0;
    logic               dclk;
    logic [7:0]         k;
    logic               mac_start;
    logic [1:0]         mac_sel;
    logic signed [13:0] mac_x;
    logic [7:0]         mac_k;
    logic               mac_done = 1'b0;
    logic               frame_done;
    logic               overrun;

    int checks   = 0;
    int failures = 0;

    seq_sample_scheduler #(.DIV(DIV), .NSAMP(NSAMP)) dut (
        .clk        (clk),
        .rst        (rst),
        .Va         (Va),
        .Vb         (Vb),
        .Vc         (Vc),
        .dclk       (dclk),
        .k          (k),
        .mac_start  (mac_start),
        .mac_sel    (mac_sel),
        .mac_x      (mac_x),
        .mac_k      (mac_k),
        .mac_done   (mac_done),
        .frame_done (frame_done),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic signed [13:0] va;
        logic signed [13:0] vb;
        logic signed [13:0] vc;
        int                 d;
        int                 kexp;
        int                 frame;
    } vec_t;

    vec_t tbl [6];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_start(input int budget);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (mac_start) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        if (!seen) chk("mac_start_timeout", 0, 1);
    endtask

    // Called in an ISSUE cycle: check operands, hold through d wait cycles, then return mac_done.
    task automatic run_phase(input int sel, input int xexp, input int kexp, input int d);
        int ok;
        chk("issue_sel", int'(mac_sel), sel);
        chk("issue_x", int'(mac_x), xexp);
        chk("issue_k", int'(mac_k), kexp);
        for (int i = 0; i < d; i++) begin
            tick();
            ok = (mac_start == 1'b0 && int'(mac_sel) == sel && int'(mac_x) == xexp &&
                  int'(mac_k) == kexp) ? 1 : 0;
            chk("wait_hold", ok, 1);
        end
        mac_done = 1'b1;
        tick();
        mac_done = 1'b0;
    endtask

    task automatic do_sample(input logic signed [13:0] va, input logic signed [13:0] vb,
                             input logic signed [13:0] vc, input int da, input int db,
                             input int dc, input int kexp, input int frame);
        Va = va;
        Vb = vb;
        Vc = vc;
        wait_start(3 * DIV);
        // Inputs move after the strobe; issued operands must come from the capture.
        Va = ~va;
        Vb = ~vb;
        Vc = ~vc;
        run_phase(0, int'(va), kexp, da);
        chk("start_b_latency", int'(mac_start), 1);
        run_phase(1, int'(vb), kexp, db);
        chk("start_c_latency", int'(mac_start), 1);
        run_phase(2, int'(vc), kexp, dc);
        chk("advance_no_start", int'(mac_start), 0);
        chk("frame_done", int'(frame_done), frame);
        tick();
        chk("k_next", int'(k), frame ? 0 : kexp + 1);
        chk("frame_done_clear", int'(frame_done), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int highs;
        int first_low;

        tbl[0] = '{-14'sd8192, 14'sd8191, -14'sd1,    3, 0, 0};
        tbl[1] = '{14'sd100,   -14'sd200, 14'sd300,   1, 1, 0};
        tbl[2] = '{14'sd4095,  -14'sd4096, 14'sd0,    4, 2, 0};
        tbl[3] = '{14'sd1,     14'sd2,    14'sd3,     2, 3, 1};
        tbl[4] = '{-14'sd1234, 14'sd5678, -14'sd8000, 3, 0, 0};
        tbl[5] = '{14'sd8191,  -14'sd8192, 14'sd42,   1, 1, 0};

        rst = 1'b1;
        tick();
        tick();
        tick();
        chk("rst_k", int'(k), 0);
        chk("rst_dclk", int'(dclk), 1);
        chk("rst_mac_start", int'(mac_start), 0);
        chk("rst_mac_sel", int'(mac_sel), 0);
        chk("rst_mac_x", int'(mac_x), 0);
        chk("rst_mac_k", int'(mac_k), 0);
        chk("rst_frame_done", int'(frame_done), 0);
        chk("rst_overrun", int'(overrun), 0);
        rst = 1'b0;

        for (int i = 0; i < 6; i++) begin
            do_sample(tbl[i].va, tbl[i].vb, tbl[i].vc, tbl[i].d, tbl[i].d, tbl[i].d,
                      tbl[i].kexp, tbl[i].frame);
        end
        chk("no_overrun_normal", int'(overrun), 0);

        // Spurious mac_done while idle between strobes.
        mac_done = 1'b1;
        tick();
        mac_done = 1'b0;
        chk("idle_done_no_start", int'(mac_start), 0);
        tick();
        chk("idle_done_no_start2", int'(mac_start), 0);
        chk("idle_done_k", int'(k), 2);

        // Phase B stalls across the next strobe: that sample is dropped.
        do_sample(14'sd11, 14'sd22, 14'sd33, 1, 30, 1, 2, 0);
        chk("overrun_set", int'(overrun), 1);
        do_sample(-14'sd5, -14'sd6, -14'sd7, 2, 2, 2, 3, 1);
        chk("overrun_sticky", int'(overrun), 1);
        do_sample(14'sd7, 14'sd8, 14'sd9, 3, 3, 3, 0, 0);

        // Reset while waiting on phase B at k=1.
        Va = 14'sd500;
        Vb = -14'sd600;
        Vc = 14'sd700;
        wait_start(3 * DIV);
        run_phase(0, 500, 1, 1);
        chk("pre_rst_start_b", int'(mac_start), 1);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_k", int'(k), 0);
        chk("midrst_overrun", int'(overrun), 0);
        chk("midrst_mac_start", int'(mac_start), 0);
        chk("midrst_mac_x", int'(mac_x), 0);
        chk("midrst_dclk", int'(dclk), 1);
        Va = -14'sd8192;
        Vb = 14'sd8191;
        Vc = -14'sd1;

        n = 0;
        highs = 0;
        first_low = -1;
        while (!mac_start && n < 5 * DIV) begin
            if (dclk) highs++;
            else if (first_low < 0) first_low = n;
            tick();
            n++;
        end
        chk("rst_to_issue_cycles", n, DIV);
        chk("dclk_high_cycles", highs, DIV / 2);
        chk("dclk_first_low", first_low, DIV / 2);

        chk("post_rst_sel", int'(mac_sel), 0);
        chk("post_rst_x", int'(mac_x), -8192);
        chk("post_rst_k", int'(mac_k), 0);
        // mac_done landing on the ISSUE cycle itself must be ignored.
        mac_done = 1'b1;
        tick();
        mac_done = 1'b0;
        chk("issue_done_ignored", int'(mac_start), 0);
        tick();
        chk("issue_done_still_wait", int'(mac_start), 0);
        mac_done = 1'b1;
        tick();
        mac_done = 1'b0;
        chk("post_rst_start_b", int'(mac_start), 1);
        run_phase(1, 8191, 0, 2);
        chk("post_rst_start_c", int'(mac_start), 1);
        run_phase(2, -1, 0, 2);
        chk("post_rst_frame", int'(frame_done), 0);
        tick();
        chk("post_rst_k_next", int'(k), 1);
        chk("post_rst_overrun", int'(overrun), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
